// File: rtl/misaligned_load_unit.sv
// Load-data unit between MEM and the data-memory port: extracts and extends
// byte/half/word/dword loads, splitting boundary-crossing loads into two reads.
//
// state | meaning
// IDLE  | ready for a request
// RD0   | reading the aligned word holding the first byte
// RD1   | reading the next aligned word (crossing loads only)
// RESP  | one-cycle response pulse
module misaligned_load_unit #(
  parameter int WIDTH         = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [2:0]       req_funct3,
  output logic             mem_req_valid,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_fault
);

  localparam int NB = WIDTH / 8;
  localparam int OB = $clog2(NB);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [2:0]       f3_q, f3_d;
  logic             cross_q, cross_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_fault_q, resp_fault_d;

  logic [3:0]       req_size;
  logic [4:0]       req_end;
  logic             req_cross;
  logic             req_illegal;
  logic [WIDTH-1:0] aligned;
  logic [WIDTH-1:0] lo_src, hi_src;
  logic [OB+2:0]    shamt;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] mask;
  logic             top_bit;
  logic [WIDTH-1:0] ext;

  // Request decode: size is 1 << funct3[1:0]; crossing when the last byte
  // falls past the end of the aligned word.
  always_comb begin
    req_size    = 4'd1 << req_funct3[1:0];
    req_end     = 5'(req_addr[OB-1:0]) + 5'(req_size);
    req_cross   = req_end > 5'(NB);
    req_illegal = (req_funct3 == 3'b111) ||
                  ((WIDTH == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
  end

  // Merge the two words and extend. In RD0 the low word comes straight from
  // memory so a non-crossing load finishes in the ack cycle.
  always_comb begin
    aligned = {addr_q[WIDTH-1:OB], {OB{1'b0}}};
    lo_src  = (state_q == RD0) ? mem_rdata : lo_q;
    hi_src  = (state_q == RD1) ? mem_rdata : '0;
    shamt   = {addr_q[OB-1:0], 3'b000};
    raw     = WIDTH'({hi_src, lo_src} >> shamt);
    case (f3_q[1:0])
      2'b00: begin
        mask    = WIDTH'(8'hFF);
        top_bit = raw[7];
      end
      2'b01: begin
        mask    = WIDTH'(16'hFFFF);
        top_bit = raw[15];
      end
      2'b10: begin
        mask    = WIDTH'(32'hFFFF_FFFF);
        top_bit = raw[31];
      end
      default: begin
        mask    = '1;
        top_bit = raw[WIDTH-1];
      end
    endcase
    ext = (raw & mask) | ({WIDTH{top_bit & ~f3_q[2]}} & ~mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      f3_q         <= '0;
      cross_q      <= 1'b0;
      lo_q         <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      f3_q         <= f3_d;
      cross_q      <= cross_d;
      lo_q         <= lo_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    f3_d         = f3_q;
    cross_d      = cross_q;
    lo_d         = lo_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          cross_d = req_cross;
          if (req_illegal || (req_cross && !MISALIGNED_EN)) begin
            state_d      = RESP;
            resp_data_d  = '0;
            resp_fault_d = 1'b1;
          end else begin
            state_d = RD0;
          end
        end
      end
      RD0: begin
        if (mem_ack) begin
          lo_d = mem_rdata;
          if (cross_q) begin
            state_d = RD1;
          end else begin
            state_d      = RESP;
            resp_data_d  = ext;
            resp_fault_d = 1'b0;
          end
        end
      end
      RD1: begin
        if (mem_ack) begin
          state_d      = RESP;
          resp_data_d  = ext;
          resp_fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE);
    mem_req_valid = (state_q == RD0) || (state_q == RD1);
    resp_valid    = (state_q == RESP);
    resp_data     = resp_data_q;
    resp_fault    = resp_fault_q;
    case (state_q)
      RD0:     mem_addr = aligned;
      RD1:     mem_addr = aligned + WIDTH'(NB);
      default: mem_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_misaligned_load_unit.sv
// Scoreboard bench for misaligned_load_unit: three instances (32-bit, 32-bit
// without misalignment support, 64-bit) share one stimulus/response path.
module tb_misaligned_load_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_funct3;
  int          sel;
  logic        force_ack;
  logic        auto_ack;
  logic [63:0] auto_rdata;
  logic        mem_ack_s;
  logic [63:0] mem_rdata_s;
  int          delay;
  int          wcnt;

  int n_chk = 0;
  int n_err = 0;

  logic [64:0] exp_q[$];
  logic [63:0] exp_addr_q[$];

  assign mem_ack_s   = force_ack | auto_ack;
  assign mem_rdata_s = force_ack ? 64'h5566_7788 : auto_rdata;

  logic        d0_rdy, d0_mrv, d0_rv, d0_rf;
  logic [31:0] d0_ma, d0_rd;
  logic        d1_rdy, d1_mrv, d1_rv, d1_rf;
  logic [31:0] d1_ma, d1_rd;
  logic        d2_rdy, d2_mrv, d2_rv, d2_rf;
  logic [63:0] d2_ma, d2_rd;

  misaligned_load_unit #(.WIDTH(32), .MISALIGNED_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel == 0), .req_ready(d0_rdy),
    .req_addr(req_addr[31:0]), .req_funct3(req_funct3),
    .mem_req_valid(d0_mrv), .mem_addr(d0_ma),
    .mem_ack(mem_ack_s && sel == 0), .mem_rdata(mem_rdata_s[31:0]),
    .resp_valid(d0_rv), .resp_data(d0_rd), .resp_fault(d0_rf)
  );

  misaligned_load_unit #(.WIDTH(32), .MISALIGNED_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel == 1), .req_ready(d1_rdy),
    .req_addr(req_addr[31:0]), .req_funct3(req_funct3),
    .mem_req_valid(d1_mrv), .mem_addr(d1_ma),
    .mem_ack(mem_ack_s && sel == 1), .mem_rdata(mem_rdata_s[31:0]),
    .resp_valid(d1_rv), .resp_data(d1_rd), .resp_fault(d1_rf)
  );

  misaligned_load_unit #(.WIDTH(64), .MISALIGNED_EN(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel == 2), .req_ready(d2_rdy),
    .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_req_valid(d2_mrv), .mem_addr(d2_ma),
    .mem_ack(mem_ack_s && sel == 2), .mem_rdata(mem_rdata_s),
    .resp_valid(d2_rv), .resp_data(d2_rd), .resp_fault(d2_rf)
  );

  logic        rdy_s, mrv_s, rv_s, rf_s;
  logic [63:0] ma_s, rd_s;

  always_comb begin
    rdy_s = d0_rdy; mrv_s = d0_mrv; rv_s = d0_rv; rf_s = d0_rf;
    ma_s  = {32'h0, d0_ma}; rd_s = {32'h0, d0_rd};
    if (sel == 1) begin
      rdy_s = d1_rdy; mrv_s = d1_mrv; rv_s = d1_rv; rf_s = d1_rf;
      ma_s  = {32'h0, d1_ma}; rd_s = {32'h0, d1_rd};
    end else if (sel == 2) begin
      rdy_s = d2_rdy; mrv_s = d2_mrv; rv_s = d2_rv; rf_s = d2_rf;
      ma_s  = d2_ma; rd_s = d2_rd;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input int s, input logic [63:0] a);
    if (s == 2) begin
      case (a)
        64'h100: return 64'h0102_0304_0506_0708;
        64'h108: return 64'hF0E0_D0C0_B0A0_9080;
        default: return 64'h0;
      endcase
    end
    case (a[31:0])
      32'h0000_0100: return 64'h8192_A3B4;
      32'h0000_0104: return 64'h5566_7788;
      32'hFFFF_FFFC: return 64'h1122_3344;
      32'h0000_0000: return 64'hAABB_CCDD;
      default:       return 64'h0;
    endcase
  endfunction

  // Memory responder: acks after `delay` waiting cycles, logs each address.
  always @(negedge clk) begin
    auto_ack = 1'b0;
    if (mrv_s && !force_ack) begin
      if (wcnt >= delay) begin
        auto_ack   = 1'b1;
        auto_rdata = mem_word(sel, ma_s);
        wcnt       = 0;
        if (exp_addr_q.size() == 0) chk("unexpected_mem_req", ma_s, 64'hx);
        else chk("mem_addr", ma_s, exp_addr_q.pop_front());
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    logic [64:0] e;
    if (rst_n && rv_s) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", rd_s, 64'hx);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", rd_s, e[63:0]);
        chk("resp_fault", {63'h0, rf_s}, {63'h0, e[64]});
      end
    end
  end

  task automatic do_load(input int s, input logic [63:0] a, input logic [2:0] f3,
                         input logic [63:0] ed, input logic ef, input int elat,
                         input int nreq, input logic [63:0] a0, input logic [63:0] a1);
    int lat;
    sel = s;
    exp_q.push_back({ef, ed});
    if (nreq > 0) exp_addr_q.push_back(a0);
    if (nreq > 1) exp_addr_q.push_back(a1);
    @(negedge clk);
    chk("req_ready_idle", {63'h0, rdy_s}, 64'h1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_funct3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rv_s && lat < 40);
    chk("latency", 64'(lat), 64'(elat));
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
    sel = 0; force_ack = 1'b0; auto_ack = 1'b0; auto_rdata = '0;
    delay = 0; wcnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_req_ready", {63'h0, rdy_s}, 64'h1);
      chk("rst_mem_req_valid", {63'h0, mrv_s}, 64'h0);
      chk("rst_mem_addr", ma_s, 64'h0);
      chk("rst_resp_valid", {63'h0, rv_s}, 64'h0);
      chk("rst_resp_data", rd_s, 64'h0);
      chk("rst_resp_fault", {63'h0, rf_s}, 64'h0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // 32-bit, misalignment supported
    do_load(0, 64'h101, 3'b000, 64'hFFFF_FFA3, 1'b0, 2, 1, 64'h100, 64'h0);
    do_load(0, 64'h103, 3'b100, 64'h0000_0081, 1'b0, 2, 1, 64'h100, 64'h0);
    do_load(0, 64'h100, 3'b010, 64'h8192_A3B4, 1'b0, 2, 1, 64'h100, 64'h0);
    do_load(0, 64'h103, 3'b001, 64'hFFFF_8881, 1'b0, 3, 2, 64'h100, 64'h104);
    do_load(0, 64'h103, 3'b101, 64'h0000_8881, 1'b0, 3, 2, 64'h100, 64'h104);
    do_load(0, 64'h102, 3'b010, 64'h7788_8192, 1'b0, 3, 2, 64'h100, 64'h104);
    do_load(0, 64'hFFFF_FFFE, 3'b010, 64'hCCDD_1122, 1'b0, 3, 2, 64'hFFFF_FFFC, 64'h0);
    do_load(0, 64'h102, 3'b001, 64'hFFFF_8192, 1'b0, 2, 1, 64'h100, 64'h0);
    do_load(0, 64'h107, 3'b000, 64'h0000_0055, 1'b0, 2, 1, 64'h104, 64'h0);
    do_load(0, 64'h100, 3'b011, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
    do_load(0, 64'h100, 3'b111, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
    do_load(0, 64'h100, 3'b110, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
    // a fault response must clear data; next good load must clear fault
    do_load(0, 64'h100, 3'b100, 64'h0000_00B4, 1'b0, 2, 1, 64'h100, 64'h0);

    // 32-bit, misalignment reported as fault
    do_load(1, 64'h101, 3'b010, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
    do_load(1, 64'h102, 3'b001, 64'hFFFF_8192, 1'b0, 2, 1, 64'h100, 64'h0);
    do_load(1, 64'h103, 3'b001, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);

    // 64-bit
    do_load(2, 64'h104, 3'b011, 64'hB0A0_9080_0102_0304, 1'b0, 3, 2, 64'h100, 64'h108);
    do_load(2, 64'h106, 3'b110, 64'h0000_0000_9080_0102, 1'b0, 3, 2, 64'h100, 64'h108);
    do_load(2, 64'h106, 3'b010, 64'hFFFF_FFFF_9080_0102, 1'b0, 3, 2, 64'h100, 64'h108);
    do_load(2, 64'h100, 3'b011, 64'h0102_0304_0506_0708, 1'b0, 2, 1, 64'h100, 64'h0);
    do_load(2, 64'h10F, 3'b000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 2, 1, 64'h108, 64'h0);
    do_load(2, 64'h100, 3'b111, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);

    // memory stall in RD0 with a competing request held on the input
    sel = 0;
    delay = 5;
    exp_q.push_back({1'b0, 64'h8192_A3B4});
    exp_addr_q.push_back(64'h100);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h100; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_addr = 64'h104; req_funct3 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("stall_mem_req_valid", {63'h0, mrv_s}, 64'h1);
      chk("stall_mem_addr", ma_s, 64'h100);
      chk("stall_mem_ack_low", {63'h0, mem_ack_s}, 64'h0);
      chk("stall_req_ready", {63'h0, rdy_s}, 64'h0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 5;
    do begin
      @(negedge clk);
      n++;
    end while (!rv_s && n < 40);
    chk("stall_latency", 64'(n), 64'd7);
    repeat (3) @(negedge clk);
    chk("stall_single_resp", 64'(exp_q.size()), 64'd0);
    chk("stall_back_to_idle", {63'h0, rdy_s}, 64'h1);

    // reset during RD1 of a crossing load, with an ack arriving in that cycle
    delay = 3;
    exp_addr_q.push_back(64'h100);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h102; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(mrv_s && ma_s == 64'h104) && n < 40);
    chk("rd1_reached", {63'h0, (mrv_s && ma_s == 64'h104)}, 64'h1);
    force_ack = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", {63'h0, rdy_s}, 64'h1);
    chk("midrst_mem_req_valid", {63'h0, mrv_s}, 64'h0);
    chk("midrst_resp_valid", {63'h0, rv_s}, 64'h0);
    @(posedge clk);
    #1 force_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", {63'h0, rv_s}, 64'h0);
    end
    delay = 0;
    do_load(0, 64'h100, 3'b010, 64'h8192_A3B4, 1'b0, 2, 1, 64'h100, 64'h0);

    repeat (2) @(negedge clk);
    chk("resp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
